gmii_mac_tx: RTL and testbench

//  GMII-side Ethernet MAC transmitter; drives gmii_tx_en/gmii_txd into gmii_to_rgmii.

---
 rtl/gmii_mac_tx_if.sv | 18 +
 rtl/gmii_mac_tx.sv | 185 ++++++++++++++++++
 tb/tb_gmii_mac_tx.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gmii_mac_tx_if.sv
// Upstream frame handshake plus GMII transmit pins of the MAC transmitter.
// The MAC side uses the slave modport; the packer/FIFO side uses master.
interface gmii_mac_tx_if;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic        tx_req;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_err;
    logic        gmii_tx_en;
    logic [7:0]  gmii_txd;

    modport master (output tx_start_en, tx_byte_num, tx_data,
                    input  tx_req, tx_busy, tx_done, tx_err, gmii_tx_en, gmii_txd);
    modport slave  (input  tx_start_en, tx_byte_num, tx_data,
                    output tx_req, tx_busy, tx_done, tx_err, gmii_tx_en, gmii_txd);
endinterface

// File: rtl/gmii_mac_tx.sv
// GMII Ethernet transmitter: preamble, SFD, payload, zero pad, CRC-32 FCS, IFG.
// Every output is registered; the next-cycle byte is chosen combinationally.
module gmii_mac_tx #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int MAX_FRAME    = 1514,
    parameter int IFG_CYCLES   = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    gmii_mac_tx_if.slave mac_if
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_SFD  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_PAD  = 3'd4;
    localparam logic [2:0] S_FCS  = 3'd5;
    localparam logic [2:0] S_IFG  = 3'd6;

    localparam logic [3:0]  PRE_LAST = 4'(PREAMBLE_LEN - 1);
    localparam logic [3:0]  IFG_LAST = 4'(IFG_CYCLES - 1);
    localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME);
    localparam logic [15:0] MAX_LEN  = 16'(MAX_FRAME);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] len_q, len_d;
    logic [15:0] bcnt_q, bcnt_d;
    logic [15:0] rcnt_q, rcnt_d;
    logic [31:0] crc_q, crc_d;
    logic        req_q, req_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        en_q, en_d;
    logic [7:0]  txd_q, txd_d;
    logic        crc_upd;

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        bcnt_d  = bcnt_q;
        rcnt_d  = rcnt_q;
        crc_d   = crc_q;
        req_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        en_d    = 1'b0;
        txd_d   = 8'h00;
        crc_upd = 1'b0;

        // Requests run two cycles ahead of the bytes they fetch, independent of the output state.
        if (req_q) begin
            rcnt_d = rcnt_q + 16'd1;
            req_d  = (rcnt_q != len_q - 16'd1);
        end

        case (state_q)
            S_IDLE: begin
                if (mac_if.tx_start_en) begin
                    if (mac_if.tx_byte_num != 16'd0 && mac_if.tx_byte_num <= MAX_LEN) begin
                        state_d = S_PRE;
                        cnt_d   = 4'd0;
                        len_d   = mac_if.tx_byte_num;
                        bcnt_d  = 16'd0;
                        rcnt_d  = 16'd0;
                        crc_d   = 32'hFFFFFFFF;
                        busy_d  = 1'b1;
                        en_d    = 1'b1;
                        txd_d   = 8'h55;
                        req_d   = (PRE_LAST == 4'd0);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_PRE: begin
                en_d = 1'b1;
                if (cnt_q == PRE_LAST) begin
                    state_d = S_SFD;
                    txd_d   = 8'hD5;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    txd_d = 8'h55;
                    req_d = req_d | (cnt_q + 4'd1 == PRE_LAST);
                end
            end
            S_SFD: begin
                en_d    = 1'b1;
                state_d = S_DATA;
                txd_d   = mac_if.tx_data;
                bcnt_d  = 16'd1;
                crc_upd = 1'b1;
            end
            S_DATA, S_PAD: begin
                en_d = 1'b1;
                if (bcnt_q < len_q) begin
                    state_d = S_DATA;
                    txd_d   = mac_if.tx_data;
                    bcnt_d  = bcnt_q + 16'd1;
                    crc_upd = 1'b1;
                end else if (bcnt_q < MIN_LEN) begin
                    state_d = S_PAD;
                    bcnt_d  = bcnt_q + 16'd1;
                    crc_upd = 1'b1;
                end else begin
                    state_d = S_FCS;
                    cnt_d   = 4'd0;
                    txd_d   = ~crc_q[7:0];
                end
            end
            S_FCS: begin
                if (cnt_q == 4'd3) begin
                    state_d = S_IFG;
                    cnt_d   = 4'd0;
                end else begin
                    en_d  = 1'b1;
                    cnt_d = cnt_q + 4'd1;
                    txd_d = ~crc_q[{cnt_d[1:0], 3'b000} +: 8];
                end
            end
            S_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (crc_upd) crc_d = crc32_byte(crc_q, txd_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            bcnt_q  <= '0;
            rcnt_q  <= '0;
            crc_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            txd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            bcnt_q  <= bcnt_d;
            rcnt_q  <= rcnt_d;
            crc_q   <= crc_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            en_q    <= en_d;
            txd_q   <= txd_d;
        end
    end

    assign mac_if.tx_req     = req_q;
    assign mac_if.tx_busy    = busy_q;
    assign mac_if.tx_done    = done_q;
    assign mac_if.tx_err     = err_q;
    assign mac_if.gmii_tx_en = en_q;
    assign mac_if.gmii_txd   = txd_q;
endmodule

// File: tb/tb_gmii_mac_tx.sv
// Scoreboard bench for gmii_mac_tx: frames are modelled as byte lists at issue time,
// and a negedge monitor pops and compares every transmitted byte.
`timescale 1ns/1ps
module tb_gmii_mac_tx;
    localparam int PRE = 7;
    localparam int MINF = 60;
    localparam int IFG = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #4 clk = ~clk;

    gmii_mac_tx_if a_if ();
    gmii_mac_tx_if b_if ();

    gmii_mac_tx u_dut (.clk(clk), .rst_n(rst_n), .mac_if(a_if));
    gmii_mac_tx #(.MIN_FRAME(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .mac_if(b_if));

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$], dat_q[$], exp0_q[$], dat0_q[$];
    int exp_len_q[$], exp_req_q[$];
    int done_cnt = 0, en_run = 0, req_run = 0, gap = 0, run0 = 0, last_run0 = 0;
    bit prev_en = 0, in_ifg = 0, req_seen_a = 0, req_seen_b = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // CRC-32 as textbook MSB-first polynomial division over bit-reversed bytes.
    function automatic logic [31:0] ref_crc(input logic [7:0] d[$]);
        logic [31:0] c;
        logic [31:0] r;
        logic [7:0] rb;
        c = 32'hFFFFFFFF;
        foreach (d[i]) begin
            for (int k = 0; k < 8; k++) rb[k] = d[i][7-k];
            c = c ^ {rb, 24'h0};
            for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
        end
        for (int k = 0; k < 32; k++) r[k] = c[31-k];
        return ~r;
    endfunction

    function automatic int pop_int(inout int q[$]);
        return (q.size() > 0) ? q.pop_front() : -1;
    endfunction

    // Upstream responder: a request seen in cycle c gets its byte during cycle c+1.
    always @(posedge clk) begin
        #1;
        if (req_seen_a) begin
            if (dat_q.size() > 0) a_if.tx_data = dat_q.pop_front();
            else check("req_overrun", dat_q.size(), 1);
        end else a_if.tx_data = 8'($urandom);
        if (req_seen_b) begin
            if (dat0_q.size() > 0) b_if.tx_data = dat0_q.pop_front();
            else check("req_overrun0", dat0_q.size(), 1);
        end else b_if.tx_data = 8'($urandom);
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en = 0; en_run = 0; req_run = 0; gap = 0; in_ifg = 0; req_seen_a = 0;
        end else begin
            req_seen_a = a_if.tx_req;
            if (a_if.tx_req) req_run++;
            if (a_if.gmii_tx_en) begin
                en_run++;
                check("busy_in_frame", a_if.tx_busy, 1);
                if (exp_q.size() == 0) check("txd_underflow", exp_q.size(), 1);
                else check("txd", a_if.gmii_txd, exp_q.pop_front());
            end else begin
                check("txd_idle", a_if.gmii_txd, 0);
                if (prev_en) begin
                    check("en_len", en_run, pop_int(exp_len_q));
                    en_run = 0; gap = 0; in_ifg = 1;
                end else if (in_ifg) gap++;
                if (in_ifg && !a_if.tx_done) check("busy_in_ifg", a_if.tx_busy, 1);
            end
            if (a_if.tx_done) begin
                done_cnt++;
                check("ifg_gap", in_ifg ? gap : -1, IFG);
                check("busy_at_done", a_if.tx_busy, 0);
                check("req_count", req_run, pop_int(exp_req_q));
                req_run = 0; in_ifg = 0;
            end
            prev_en = a_if.gmii_tx_en;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            req_seen_b = 0; run0 = 0;
        end else begin
            req_seen_b = b_if.tx_req;
            if (b_if.gmii_tx_en) begin
                run0++;
                if (exp0_q.size() == 0) check("txd0_underflow", exp0_q.size(), 1);
                else check("txd0", b_if.gmii_txd, exp0_q.pop_front());
            end else if (run0 != 0) begin
                last_run0 = run0; run0 = 0;
            end
        end
    end

    task automatic issue(input int len, input bit rnd, input bit hold);
        logic [7:0] body[$];
        logic [31:0] crc;
        for (int i = 0; i < len; i++) body.push_back(rnd ? 8'($urandom) : 8'(i));
        foreach (body[i]) dat_q.push_back(body[i]);
        while (body.size() < MINF) body.push_back(8'h00);
        crc = ref_crc(body);
        repeat (PRE) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (body[i]) exp_q.push_back(body[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(crc >> (8 * i)));
        exp_len_q.push_back(1 + PRE + body.size() + 4);
        exp_req_q.push_back(len);
        @(negedge clk);
        a_if.tx_start_en = 1'b1;
        a_if.tx_byte_num = 16'(len);
        if (!hold) begin
            @(negedge clk);
            a_if.tx_start_en = 1'b0;
            check("busy_rise", a_if.tx_busy, 1);
        end
    endtask

    task automatic wait_done(input int limit, input bit hold);
        bit seen = 0;
        for (int k = 0; k < limit && !seen; k++) begin
            @(negedge clk);
            if (a_if.tx_done) seen = 1;
            if (hold) begin
                a_if.tx_start_en = !seen;
                a_if.tx_byte_num = 16'($urandom_range(1, 1514));
            end
        end
        a_if.tx_start_en = 1'b0;
        check("done_seen", seen, 1);
        check("exp_drained", exp_q.size(), 0);
    endtask

    task automatic bad_start(input int len);
        @(negedge clk);
        a_if.tx_start_en = 1'b1;
        a_if.tx_byte_num = 16'(len);
        @(negedge clk);
        a_if.tx_start_en = 1'b0;
        check("err_pulse", a_if.tx_err, 1);
        check("err_busy", a_if.tx_busy, 0);
        check("err_en", a_if.gmii_tx_en, 0);
        @(negedge clk);
        check("err_clear", a_if.tx_err, 0);
        check("err_busy2", a_if.tx_busy, 0);
    endtask

    initial begin
        int d0;
        bit seen0;
        logic [7:0] ascii[9];
        a_if.tx_start_en = 0; a_if.tx_byte_num = 0; a_if.tx_data = 0;
        b_if.tx_start_en = 0; b_if.tx_byte_num = 0; b_if.tx_data = 0;
        #5;
        check("rst_en", a_if.gmii_tx_en, 0);
        check("rst_txd", a_if.gmii_txd, 0);
        check("rst_req", a_if.tx_req, 0);
        check("rst_busy", a_if.tx_busy, 0);
        check("rst_done", a_if.tx_done, 0);
        check("rst_err", a_if.tx_err, 0);
        check("rst_en0", b_if.gmii_tx_en, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reference vector on the unpadded instance.
        for (int i = 0; i < 9; i++) ascii[i] = 8'h31 + 8'(i);
        foreach (ascii[i]) dat0_q.push_back(ascii[i]);
        repeat (PRE) exp0_q.push_back(8'h55);
        exp0_q.push_back(8'hD5);
        foreach (ascii[i]) exp0_q.push_back(ascii[i]);
        exp0_q.push_back(8'h26); exp0_q.push_back(8'h39);
        exp0_q.push_back(8'hF4); exp0_q.push_back(8'hCB);
        @(negedge clk);
        b_if.tx_start_en = 1'b1; b_if.tx_byte_num = 16'd9;
        @(negedge clk);
        b_if.tx_start_en = 1'b0;
        seen0 = 0;
        for (int k = 0; k < 100 && !seen0; k++) begin
            @(negedge clk);
            if (b_if.tx_done) seen0 = 1;
        end
        check("done0_seen", seen0, 1);
        check("exp0_drained", exp0_q.size(), 0);
        check("en0_len", last_run0, 21);

        issue(14, 0, 0);   wait_done(200, 0);
        issue(1, 1, 0);    wait_done(200, 0);
        issue(59, 1, 0);   wait_done(200, 0);
        issue(60, 1, 0);   wait_done(200, 0);
        issue(61, 1, 0);   wait_done(200, 0);
        issue(1514, 1, 0); wait_done(1700, 0);

        bad_start(0);
        bad_start(1515);

        // Start held high for the whole frame, including the last IFG cycle.
        issue(40, 1, 1);   wait_done(200, 1);
        repeat (20) @(negedge clk);
        check("no_restart_busy", a_if.tx_busy, 0);
        check("no_restart_en", a_if.gmii_tx_en, 0);

        // Reset in the middle of the payload.
        issue(100, 1, 0);
        repeat (28) @(negedge clk);
        check("en_before_rst", a_if.gmii_tx_en, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_en", a_if.gmii_tx_en, 0);
        check("arst_txd", a_if.gmii_txd, 0);
        check("arst_req", a_if.tx_req, 0);
        check("arst_busy", a_if.tx_busy, 0);
        exp_q.delete(); dat_q.delete(); exp_len_q.delete(); exp_req_q.delete();
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("no_done_after_rst", done_cnt, d0);

        issue(30, 1, 0);   wait_done(200, 0);
        repeat (4) begin
            issue($urandom_range(1, 150), 1, 0);
            wait_done(300, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected completion before 1 ms");
        $fatal(1);
    end
endmodule
